// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Combinational full-adder cell shared across all bit positions.
module serial_adder_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH cycles, LSB first.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // state  | meaning
  // S_IDLE | waiting for start; operands captured on start
  // S_RUN  | one bit pair per cycle through the cell
  // S_DONE | one-cycle result-valid pulse

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, acc, acc_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             cell_sum, cell_carry;
  logic             last_bit;

  serial_adder_ctrl_fa u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = cell_sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          acc     <= acc_next;
          carry_q <= cell_carry;
          cnt     <= cnt + CW'(1);
          // Result registers only move on the final bit so no partial sum is visible.
          if (last_bit) begin
            sum  <= acc_next;
            cout <= cell_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
